// File: rtl/board_scanner_pkg.sv
// Shared definitions for the board scanner: board geometry, default tile pitch,
// tile colour codes and the scanner state encoding.
package board_scanner_pkg;

  localparam int unsigned BOARD_DIM  = 8;
  localparam int unsigned NUM_CELLS  = BOARD_DIM * BOARD_DIM;
  localparam int unsigned IDX_W      = 6;

  localparam int unsigned DEF_TILE_W = 20;
  localparam int unsigned DEF_TILE_H = 15;

  // 3-bit RGB tile colours
  localparam logic [2:0] COL_HIDDEN = 3'b111;
  localparam logic [2:0] COL_FLAG   = 3'b100;
  localparam logic [2:0] COL_STEP   = 3'b001;
  localparam logic [2:0] COL_MINE   = 3'b000;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StScan,
    StEmit,
    StDone
  } state_e;

endpackage

// File: rtl/board_scanner_cell_color.sv
// Combinational cell classifier: maps one cell's mine/flag/step bits plus the
// game-over flag onto the tile colour to draw.
// Ports:
//   mine, flag, step  in   cell state bits
//   game_over         in   reveal all unflagged mines
//   color             out  3-bit RGB tile colour
module board_scanner_cell_color
  import board_scanner_pkg::*;
(
  input  logic       mine,
  input  logic       flag,
  input  logic       step,
  input  logic       game_over,
  output logic [2:0] color
);

  always_comb begin
    color = COL_HIDDEN;
    if ((step && mine) || (game_over && mine && !flag)) begin
      color = COL_MINE;
    end else if (flag && !step) begin
      color = COL_FLAG;
    end else if (step) begin
      color = COL_STEP;
    end
  end

endmodule

// File: rtl/board_scanner.sv
// Board scanner: on request, snapshots the mine/flag/step maps, walks the 8x8
// board in index order and issues one (x, y, colour) tile draw request per cell
// over a valid/ready handshake. A start seen while busy queues one more pass.
// Optional build macro DIRTY_TRACK_EN: keep a shadow of the last drawn colour
// per cell and skip cells whose colour has not changed since the last full pass.
// Ports:
//   clk, resetn                   clock, synchronous active-low reset
//   start                         request a board pass
//   mine_map, flag_map, step_map  board state, bit i = cell row*8+col
//   game_over                     reveal all unflagged mines
//   tile_x, tile_y, tile_color    tile request payload
//   tile_valid, tile_ready        tile request handshake
//   busy                          pass in progress
//   frame_done                    one-cycle pulse at the end of a pass
module board_scanner
  import board_scanner_pkg::*;
#(
  parameter int unsigned TILE_W   = DEF_TILE_W,
  parameter int unsigned TILE_H   = DEF_TILE_H,
  parameter int unsigned ORIGIN_X = 0,
  parameter int unsigned ORIGIN_Y = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [63:0] mine_map,
  input  logic [63:0] flag_map,
  input  logic [63:0] step_map,
  input  logic        game_over,
  output logic [7:0]  tile_x,
  output logic [6:0]  tile_y,
  output logic [2:0]  tile_color,
  output logic        tile_valid,
  input  logic        tile_ready,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [7:0] OrgX  = 8'(ORIGIN_X);
  localparam logic [6:0] OrgY  = 7'(ORIGIN_Y);
  localparam logic [7:0] StepX = 8'(TILE_W);
  localparam logic [6:0] StepY = 7'(TILE_H);

  state_e           state_q;
  logic [63:0]      mine_q, flag_q, step_q;
  logic             go_q;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       cur_x_q;
  logic [6:0]       cur_y_q;
  logic [7:0]       tile_x_q;
  logic [6:0]       tile_y_q;
  logic [2:0]       color_q;
  logic             pending_q;

  logic [2:0]       cell_col;
  logic             draw;
  logic             last;
  logic             advance;

  board_scanner_cell_color u_cell_color (
    .mine      (mine_q[idx_q]),
    .flag      (flag_q[idx_q]),
    .step      (step_q[idx_q]),
    .game_over (go_q),
    .color     (cell_col)
  );

`ifdef DIRTY_TRACK_EN
  logic [2:0] shadow_q [NUM_CELLS];
  logic       shadow_valid_q;

  always_ff @(posedge clk) begin
    if (resetn && state_q == StEmit && tile_ready) begin
      shadow_q[idx_q] <= color_q;
    end
  end

  // Shadow only becomes trustworthy once a whole pass has been drawn.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      shadow_valid_q <= 1'b0;
    end else if (state_q == StDone) begin
      shadow_valid_q <= 1'b1;
    end
  end

  assign draw = !(shadow_valid_q && (cell_col == shadow_q[idx_q]));
`else
  assign draw = 1'b1;
`endif

  assign last    = (idx_q == IDX_W'(NUM_CELLS - 1));
  assign advance = ((state_q == StScan) && !draw) || ((state_q == StEmit) && tile_ready);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= StIdle;
      mine_q    <= '0;
      flag_q    <= '0;
      step_q    <= '0;
      go_q      <= 1'b0;
      idx_q     <= '0;
      cur_x_q   <= OrgX;
      cur_y_q   <= OrgY;
      tile_x_q  <= OrgX;
      tile_y_q  <= OrgY;
      color_q   <= 3'b000;
      pending_q <= 1'b0;
    end else begin
      if (start && (state_q != StIdle)) begin
        pending_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StLoad;
            pending_q <= 1'b0;
          end
        end
        StLoad: begin
          mine_q  <= mine_map;
          flag_q  <= flag_map;
          step_q  <= step_map;
          go_q    <= game_over;
          idx_q   <= '0;
          cur_x_q <= OrgX;
          cur_y_q <= OrgY;
          state_q <= StScan;
        end
        StScan: begin
          if (draw) begin
            tile_x_q <= cur_x_q;
            tile_y_q <= cur_y_q;
            color_q  <= cell_col;
            state_q  <= StEmit;
          end else begin
            state_q <= last ? StDone : StScan;
          end
        end
        StEmit: begin
          if (tile_ready) begin
            state_q <= last ? StDone : StScan;
          end
        end
        StDone: begin
          // A start arriving in this very cycle also counts as pending.
          if (pending_q || start) begin
            state_q   <= StLoad;
            pending_q <= 1'b0;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Step to the next cell; coordinates accumulate, no multipliers.
      if (advance && !last) begin
        idx_q <= idx_q + IDX_W'(1);
        if (idx_q[2:0] == 3'd7) begin
          cur_x_q <= OrgX;
          cur_y_q <= cur_y_q + StepY;
        end else begin
          cur_x_q <= cur_x_q + StepX;
        end
      end
    end
  end

  assign tile_x     = tile_x_q;
  assign tile_y     = tile_y_q;
  assign tile_color = color_q;
  assign tile_valid = (state_q == StEmit);
  assign busy       = (state_q != StIdle);
  assign frame_done = (state_q == StDone);

endmodule

// File: tb/tb_board_scanner.sv
// Self-checking bench for board_scanner. A reference model pushes the expected
// (x, y, colour) sequence of each pass into a queue; a monitor pops and compares
// on every accepted tile. Also honours DIRTY_TRACK_EN when defined.
module tb_board_scanner;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [63:0] mine_map, flag_map, step_map;
  logic        game_over;
  logic [7:0]  tile_x;
  logic [6:0]  tile_y;
  logic [2:0]  tile_color;
  logic        tile_valid;
  logic        tile_ready;
  logic        busy;
  logic        frame_done;

  board_scanner dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .mine_map   (mine_map),
    .flag_map   (flag_map),
    .step_map   (step_map),
    .game_over  (game_over),
    .tile_x     (tile_x),
    .tile_y     (tile_y),
    .tile_color (tile_color),
    .tile_valid (tile_valid),
    .tile_ready (tile_ready),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int xfer_cnt = 0;
  int fd_cnt   = 0;

  logic [17:0] exp_q[$];
  logic [2:0]  m_shadow [64];
  bit          m_shadow_valid = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] model_color(input logic m, input logic f, input logic s,
                                             input logic g);
    if ((s && m) || (g && m && !f)) return 3'b000;
    if (f && !s) return 3'b100;
    if (s) return 3'b001;
    return 3'b111;
  endfunction

  // Push the tiles one pass over these maps is expected to emit.
  task automatic push_expected(input logic [63:0] m, input logic [63:0] f, input logic [63:0] s,
                               input logic g, output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
      bit         emit;
      x    = 8'((i % 8) * 20);
      y    = 7'((i / 8) * 15);
      c    = model_color(m[i], f[i], s[i], g);
      emit = 1'b1;
`ifdef DIRTY_TRACK_EN
      if (m_shadow_valid && m_shadow[i] == c) emit = 1'b0;
      m_shadow[i] = c;
`endif
      if (emit) begin
        exp_q.push_back({x, y, c});
        n++;
      end
    end
    m_shadow_valid = 1'b1;
  endtask

  always @(negedge clk) begin
    if (resetn && tile_valid && tile_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_tile", {14'd0, tile_x, tile_y, tile_color}, 32'hffff_ffff);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        check_eq("tile_xyc", {14'd0, tile_x, tile_y, tile_color}, {14'd0, e});
      end
      xfer_cnt++;
    end
    if (resetn && frame_done) fd_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    resetn     = 1'b0;
    start      = 1'b0;
    tile_ready = 1'b1;
    tick();
    tick();
    resetn = 1'b1;
    exp_q.delete();
    m_shadow_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (!busy) break;
      tick();
    end
    if (i >= budget) check_eq("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_maps(input logic [63:0] m, input logic [63:0] f, input logic [63:0] s,
                          input logic g);
    mine_map  = m;
    flag_map  = f;
    step_map  = s;
    game_over = g;
  endtask

  task automatic run_pass(input logic [63:0] m, input logic [63:0] f, input logic [63:0] s,
                          input logic g, input bit lat);
    int n, x0, f0;
    set_maps(m, f, s, g);
    push_expected(m, f, s, g, n);
    x0 = xfer_cnt;
    f0 = fd_cnt;
    pulse_start();
    if (lat) begin
      check_eq("lat_load_busy", busy, 1);
      check_eq("lat_load_valid", tile_valid, 0);
      tick();
      check_eq("lat_scan_valid", tile_valid, 0);
      tick();
      check_eq("lat_emit_valid", tile_valid, 1);
    end
    wait_idle(400);
    check_eq("frame_done_cnt", fd_cnt - f0, 1);
    check_eq("xfer_cnt", xfer_cnt - x0, n);
    check_eq("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, na, nb, x0, f0, i;
    set_maps('0, '0, '0, 1'b0);
    do_reset();
    check_eq("rst_valid", tile_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", frame_done, 0);
    check_eq("rst_x", tile_x, 0);
    check_eq("rst_y", tile_y, 0);
    check_eq("rst_color", tile_color, 0);

    // All-hidden board with latency check
    run_pass('0, '0, '0, 1'b0, 1'b1);
    // Stepped-on mine at cell 5
    run_pass(64'h1 << 5, '0, 64'h1 << 5, 1'b0, 1'b0);
    // Game over: unflagged mine revealed, then flagged mine stays red
    run_pass(64'h1 << 10, '0, '0, 1'b1, 1'b0);
    run_pass(64'h1 << 10, 64'h1 << 10, '0, 1'b1, 1'b0);

    // Backpressure on cell 3
    do_reset();
    set_maps('0, '0, '0, 1'b0);
    push_expected('0, '0, '0, 1'b0, n);
    x0 = xfer_cnt;
    f0 = fd_cnt;
    pulse_start();
    for (i = 0; i < 100 && (xfer_cnt - x0) != 3; i++) tick();
    if (i >= 100) check_eq("stall_reach_timeout", 0, 1);
    tile_ready = 1'b0;
    for (i = 0; i < 10 && !tile_valid; i++) tick();
    if (i >= 10) check_eq("stall_valid_timeout", 0, 1);
    for (int k = 0; k < 7; k++) begin
      check_eq("stall_valid", tile_valid, 1);
      check_eq("stall_xyc", {14'd0, tile_x, tile_y, tile_color}, {14'd0, 8'd60, 7'd0, 3'b111});
      tick();
    end
    tile_ready = 1'b1;
    wait_idle(400);
    check_eq("stall_frame_done_cnt", fd_cnt - f0, 1);
    check_eq("stall_xfer_cnt", xfer_cnt - x0, n);

    // Double start mid-pass collapses to one extra pass; map change not seen mid-pass
    set_maps(64'h8000_0000_0000_0401, 64'h0100_0000_0000_0400, 64'h0000_0000_00ff_0001, 1'b0);
    push_expected(mine_map, flag_map, step_map, game_over, na);
    x0 = xfer_cnt;
    f0 = fd_cnt;
    pulse_start();
    repeat (20) tick();
    set_maps('0, '0, 64'hffff_0000_0000_0000, 1'b0);
    pulse_start();
    repeat (5) tick();
    pulse_start();
    push_expected(mine_map, flag_map, step_map, game_over, nb);
    wait_idle(800);
    check_eq("dbl_frame_done_cnt", fd_cnt - f0, 2);
    check_eq("dbl_xfer_cnt", xfer_cnt - x0, na + nb);
    check_eq("dbl_queue_empty", exp_q.size(), 0);

    // Reset while cell 20 is being offered
    do_reset();
    set_maps('0, '0, '0, 1'b0);
    push_expected('0, '0, '0, 1'b0, n);
    x0 = xfer_cnt;
    pulse_start();
    for (i = 0; i < 200 && !((xfer_cnt - x0) == 20 && tile_valid); i++) tick();
    if (i >= 200) check_eq("rst20_reach_timeout", 0, 1);
    check_eq("rst20_x_before", tile_x, 80);
    resetn     = 1'b0;
    tile_ready = 1'b0;
    tick();
    check_eq("rst20_valid", tile_valid, 0);
    check_eq("rst20_busy", busy, 0);
    check_eq("rst20_xyc", {14'd0, tile_x, tile_y, tile_color}, 32'd0);
    exp_q.delete();
    m_shadow_valid = 1'b0;
    resetn     = 1'b1;
    tile_ready = 1'b1;
    repeat (3) tick();
    check_eq("rst20_stays_idle", busy, 0);

    // Two passes, only flag 63 changes on the second
    run_pass('0, '0, '0, 1'b0, 1'b0);
    x0 = xfer_cnt;
    run_pass('0, 64'h1 << 63, '0, 1'b0, 1'b0);
`ifdef DIRTY_TRACK_EN
    check_eq("dirty_one_tile", xfer_cnt - x0, 1);
`else
    check_eq("full_pass_tiles", xfer_cnt - x0, 64);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
